alu_arbiter: RTL
================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared `ALU_design` datapath. It accepts operations from two clients over valid/ready handshakes, drives the ALU operand and command ports, and waits the command-dependent ALU latency. It then captures the result and flags and returns them with the requester ID over a valid/ready response channel. It sits between the two datapath clients and the single ALU instance; one operation is in flight at a time.

## Interface
- WIDTH_O, 8, operand width (matches ALU)
- WIDTH_C, 4, command width (matches ALU)
- LAT, 1, ALU latency in CE-cycles for non-multiply commands (≥1)
- MUL_LAT, 2, ALU latency for MODE=1, CMD=9 or 10 (≥1)
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- REQ_VALID  in  2  per-requester request valid (bit n = requester n)
- REQ_READY  out  2  per-requester accept; one-hot or zero
- REQ_MODE  in  2  per-requester MODE
- REQ_CMD  in  2*WIDTH_C  per-requester CMD, requester n at [n*WIDTH_C +: WIDTH_C]
- REQ_OPA, REQ_OPB  in  2*WIDTH_O  per-requester operands, same packing
- REQ_CIN  in  2  per-requester carry-in
- REQ_INP_VALID  in  4  per-requester INP_VALID, requester n at [2n +: 2]
- ALU_OPA, ALU_OPB  out  WIDTH_O  to ALU OPA_1/OPB_1
- ALU_CMD  out  WIDTH_C;  ALU_MODE, ALU_CIN, ALU_CE  out  1;  ALU_INP_VALID  out  2
- ALU_RES  in  2*WIDTH_O+1  from ALU RES
- ALU_FLAGS  in  6  {COUT,OFLOW,G,E,L,ERR} from ALU
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response accept
- RSP_ID  out  1  requester served
- RSP_RES  out  2*WIDTH_O+1  captured result
- RSP_FLAGS  out  6  captured {COUT,OFLOW,G,E,L,ERR}

## Operation
- States: IDLE, EXEC, RESP. Priority pointer PRI (1 bit).
- IDLE: grant g = PRI if REQ_VALID[PRI], else the other requester if valid. REQ_READY[g]=1 combinationally; all READY=0 outside IDLE.
- Accept edge (VALID&READY): latch MODE/CMD/OPA/OPB/CIN/INP_VALID and ID=g into ALU_* / ID registers.
  - If INP_VALID=00: skip the ALU. Load RSP_RES=0, RSP_FLAGS=6'b000001 (ERR only), go to RESP.
  - Otherwise: load CNT = MUL_LAT if MODE=1 and CMD∈{9,10}, else LAT. Go to EXEC.
- EXEC: ALU_CE=1, ALU_* held stable. While CNT≠0, CNT decrements each edge. In the cycle CNT==0, ALU outputs are valid: on that edge capture ALU_RES→RSP_RES and ALU_FLAGS→RSP_FLAGS, then go to RESP.
- RESP: RSP_VALID=1. RSP_ID/RES/FLAGS held stable until RSP_READY. On the VALID&READY edge: PRI ← ~RSP_ID, go to IDLE.
- ALU_CE=0 in IDLE and RESP, so the ALU holds its outputs.
- REQ_VALID deassert before grant: no effect. Request payload is only sampled on the accept edge.
- Both valid in IDLE: PRI decides. Strict alternation under continuous contention.

## Timing
- Reset (any state, mid-operation included): state=IDLE, PRI=0, CNT=0. ALU_*=0, ALU_CE=0, RSP_VALID=0, RSP_ID=0, RSP_RES=0, RSP_FLAGS=0, REQ_READY=0 while RST=1. The in-flight op is dropped and no response is issued.
- Accept at edge E0 → ALU_CE high in cycles after E0 through E(L). Capture at E(L+1) → RSP_VALID high from E(L+1). L = LAT or MUL_LAT.
- INP_VALID=00: RSP_VALID high from E1.
- Earliest next accept is the edge after the response handshake. Minimum op period is L+3 cycles.
- RSP_READY held high in RESP: handshake completes on the first RESP edge.

## Test plan
- Single op: req0 MODE=1 CMD=0 OPA=10 OPB=20, RSP_READY=1, LAT=1 → ALU_CE high 2 cycles, RSP_VALID at accept+2, RSP_RES=30, RSP_ID=0.
- Multiply latency: req1 MODE=1 CMD=9 OPA=7 OPB=5, MUL_LAT=2 → CE high 3 cycles, RSP_RES=48 at accept+3, RSP_ID=1.
- Contention: both valid continuously for 4 ops after reset → grant order 0,1,0,1; REQ_READY never two-hot.
- Backpressure: hold RSP_READY=0 for 5 cycles in RESP → RSP_* stable, REQ_READY=0, ALU_CE=0; release → IDLE next cycle.
- INP_VALID=00 from req0 → ALU_CE never high, RSP at accept+1 with RES=0, FLAGS=000001.
- Reset mid-EXEC of MUL op → next cycle state IDLE, all outputs 0, no RSP_VALID; a new req0 ADD then completes normally with PRI=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared ALU: grants one operation
// at a time, sequences the ALU through its command latency and returns the result.
module alu_arbiter #(
  parameter int WIDTH_O = 8,
  parameter int WIDTH_C = 4,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             REQ_VALID,
  output logic [1:0]             REQ_READY,
  input  logic [1:0]             REQ_MODE,
  input  logic [2*WIDTH_C-1:0]   REQ_CMD,
  input  logic [2*WIDTH_O-1:0]   REQ_OPA,
  input  logic [2*WIDTH_O-1:0]   REQ_OPB,
  input  logic [1:0]             REQ_CIN,
  input  logic [3:0]             REQ_INP_VALID,
  output logic [WIDTH_O-1:0]     ALU_OPA,
  output logic [WIDTH_O-1:0]     ALU_OPB,
  output logic [WIDTH_C-1:0]     ALU_CMD,
  output logic                   ALU_MODE,
  output logic                   ALU_CIN,
  output logic                   ALU_CE,
  output logic [1:0]             ALU_INP_VALID,
  input  logic [2*WIDTH_O:0]     ALU_RES,
  input  logic [5:0]             ALU_FLAGS,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic                   RSP_ID,
  output logic [2*WIDTH_O:0]     RSP_RES,
  output logic [5:0]             RSP_FLAGS
);

  localparam int MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic               pri;
  logic               skip;
  logic [CNT_W-1:0]   cnt;

  logic               gnt_vld;
  logic               gnt;
  logic               sel_mode;
  logic [WIDTH_C-1:0] sel_cmd;
  logic [WIDTH_O-1:0] sel_opa;
  logic [WIDTH_O-1:0] sel_opb;
  logic               sel_cin;
  logic [1:0]         sel_iv;
  logic               is_mul;

  // Grant: the priority holder wins if it asks, otherwise the other requester.
  always_comb begin
    gnt_vld = |REQ_VALID;
    gnt     = REQ_VALID[pri] ? pri : ~pri;
  end

  always_comb begin
    sel_mode = gnt ? REQ_MODE[1] : REQ_MODE[0];
    sel_cmd  = gnt ? REQ_CMD[2*WIDTH_C-1:WIDTH_C] : REQ_CMD[WIDTH_C-1:0];
    sel_opa  = gnt ? REQ_OPA[2*WIDTH_O-1:WIDTH_O] : REQ_OPA[WIDTH_O-1:0];
    sel_opb  = gnt ? REQ_OPB[2*WIDTH_O-1:WIDTH_O] : REQ_OPB[WIDTH_O-1:0];
    sel_cin  = gnt ? REQ_CIN[1] : REQ_CIN[0];
    sel_iv   = gnt ? REQ_INP_VALID[3:2] : REQ_INP_VALID[1:0];
    is_mul   = sel_mode && ((sel_cmd == WIDTH_C'(9)) || (sel_cmd == WIDTH_C'(10)));
  end

  always_comb begin
    REQ_READY = 2'b00;
    if (!RST && (state == IDLE) && gnt_vld)
      REQ_READY[gnt] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      pri           <= 1'b0;
      skip          <= 1'b0;
      cnt           <= '0;
      ALU_OPA       <= '0;
      ALU_OPB       <= '0;
      ALU_CMD       <= '0;
      ALU_MODE      <= 1'b0;
      ALU_CIN       <= 1'b0;
      ALU_CE        <= 1'b0;
      ALU_INP_VALID <= 2'b00;
      RSP_VALID     <= 1'b0;
      RSP_ID        <= 1'b0;
      RSP_RES       <= '0;
      RSP_FLAGS     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            ALU_OPA       <= sel_opa;
            ALU_OPB       <= sel_opb;
            ALU_CMD       <= sel_cmd;
            ALU_MODE      <= sel_mode;
            ALU_CIN       <= sel_cin;
            ALU_INP_VALID <= sel_iv;
            RSP_ID        <= gnt;
            state         <= EXEC;
            // No valid operands: bypass the ALU and report ERR one cycle later.
            if (sel_iv == 2'b00) begin
              skip      <= 1'b1;
              RSP_RES   <= '0;
              RSP_FLAGS <= 6'b000001;
            end else begin
              ALU_CE <= 1'b1;
              cnt    <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
            end
          end
        end
        EXEC: begin
          if (skip) begin
            skip      <= 1'b0;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            RSP_RES   <= ALU_RES;
            RSP_FLAGS <= ALU_FLAGS;
            RSP_VALID <= 1'b1;
            ALU_CE    <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            pri       <= ~RSP_ID;
            RSP_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
